// File: rtl/fir_out_packer.sv
// fir_out_packer: narrows FIR results to Q1.15, buffers them in a first-word-fall-through
// FIFO and drives a framed AXI-Stream master. Define FIR_OUT_SAT_EN for saturating narrowing.
module fir_out_packer #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_tvalid,
  input  logic [IN_WIDTH-1:0]           s_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [OUT_WIDTH-1:0]          m_tdata,
  output logic                          m_tlast,
  input  logic                          clr_ovf,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int FW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int LAST_I = FRAME_LEN - 1;

  localparam logic [AW:0]   DEPTH_C    = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE_C  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE_C  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0] FRM_LAST_C = LAST_I[FW-1:0];
  localparam logic [FW-1:0] FRM_ONE_C  = {{(FW-1){1'b0}}, 1'b1};

  logic [OUT_WIDTH-1:0] narrow_s;
  logic [OUT_WIDTH-1:0] data1_r;
  logic                 v1_r;
  logic [OUT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [AW:0]          count_r;
  logic [FW-1:0]        frame_r;
  logic                 ovf_r;
  logic [15:0]          drop_r;
  logic                 pop_s;
  logic                 push_s;
  logic                 drop_s;
  logic                 nonempty_s;

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX_C =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN_C =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [IN_WIDTH-1:0] x);
    if (x > SAT_MAX_C) begin
      narrow = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (x < SAT_MIN_C) begin
      narrow = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      narrow = x[OUT_WIDTH-1:0];
    end
  endfunction

  assign narrow_s = narrow(s_tdata);
`else
  // Plain two's-complement wrap: the upper result bits are intentionally discarded.
  function automatic logic [OUT_WIDTH-1:0] narrow(input logic [OUT_WIDTH-1:0] x);
    narrow = x;
  endfunction

  logic unused_hi_s;
  assign unused_hi_s = ^s_tdata[IN_WIDTH-1:OUT_WIDTH];
  assign narrow_s    = narrow(s_tdata[OUT_WIDTH-1:0]);
`endif

  assign nonempty_s = (count_r != {(AW+1){1'b0}});

  // Push/pop/drop decisions; a full FIFO still accepts when it pops in the same cycle.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (nonempty_s && m_tready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (v1_r) begin
      push_s = (count_r < DEPTH_C) || pop_s;
      drop_s = !push_s;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Stage 1: narrowing register and its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      data1_r <= {OUT_WIDTH{1'b0}};
      v1_r    <= 1'b0;
    end else begin
      v1_r <= s_tvalid;
      if (s_tvalid) begin
        data1_r <= narrow_s;
      end
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data1_r;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame position of the head beat; advances only on pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_r <= {FW{1'b0}};
    end else if (pop_s) begin
      if (frame_r == FRM_LAST_C) begin
        frame_r <= {FW{1'b0}};
      end else begin
        frame_r <= frame_r + FRM_ONE_C;
      end
    end
  end

  // Drop bookkeeping; a clear coinciding with a drop leaves a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r  <= 1'b0;
      drop_r <= 16'h0000;
    end else if (clr_ovf) begin
      ovf_r  <= drop_s;
      drop_r <= drop_s ? 16'h0001 : 16'h0000;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
      if (drop_r != 16'hFFFF) begin
        drop_r <= drop_r + 16'h0001;
      end
    end
  end

  assign m_tvalid   = nonempty_s;
  assign m_tdata    = nonempty_s ? mem_r[rd_ptr_r] : {OUT_WIDTH{1'b0}};
  assign m_tlast    = nonempty_s && (frame_r == FRM_LAST_C);
  assign overflow   = ovf_r;
  assign drop_count = drop_r;
  assign fill_level = count_r;

endmodule
